// File: rtl/uart_pkg.sv
// Shared UART receive types: parity encoding, frame width, RX FIFO entry layout
// and the frame decoder used by the receive controller.
package uart_pkg;

  localparam int FRAME_W = 11;

  // Code 2'b11 is unnamed; it decodes as odd because only bit 1 selects the sense.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_EVEN = 2'b01,
    PARITY_ODD  = 2'b10
  } parity_e;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  function automatic rx_entry_t decode_frame(
    input logic [FRAME_W-1:0] pkt,
    input logic               ds,
    input logic [1:0]         par,
    input logic               two_stop
  );
    rx_entry_t  e;
    logic [3:0] par_idx;
    logic [3:0] stop_idx;
    logic       par_en;
    e.data   = ds ? pkt[7:0] : {1'b0, pkt[6:0]};
    par_idx  = ds ? 4'd8 : 4'd7;
    par_en   = (par != PARITY_NONE);
    e.pe     = par_en & ((^e.data ^ pkt[par_idx]) != par[1]);
    stop_idx = par_idx + {3'b000, par_en};
    e.fe     = ~pkt[stop_idx] | (two_stop & ~pkt[stop_idx + 4'd1]);
    return e;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// Head data reads as zero while the FIFO is empty.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (AW+1)'(DEPTH));
  assign count_o = count_reg;
  assign rdata_o = empty_o ? '0 : mem[rd_ptr_reg];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/rx_controller.sv
// UART receive controller: registered frame decode, FIFO push/pop gating and
// sticky overrun tracking between the RX frontend and the register file.
module rx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cr_ds_i,
  input  logic [1:0]                  cr_p_i,
  input  logic                        cr_s_i,
  input  logic [FRAME_W-1:0]          packet_i,
  input  logic                        packet_valid_i,
  input  logic                        rx_read_i,
  input  logic                        ovr_clear_i,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_pe_o,
  output logic                        rx_fe_o,
  output logic                        rx_ready_o,
  output logic                        rx_full_o,
  output logic                        rx_ovr_o,
  output logic [$clog2(FIFO_DEPTH):0] rx_count_o
);

  rx_entry_t dec_entry_reg;
  logic      dec_valid_reg;
  logic      ovr_reg;
  logic      ovr_next;
  logic      fifo_push;
  logic      fifo_drop;
  logic      fifo_empty;
  logic      fifo_full;
  logic [$bits(rx_entry_t)-1:0] fifo_rdata;
  rx_entry_t head;

  // Config is sampled only on the strobe, so later cr_* changes never touch buffered frames.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_valid_reg <= 1'b0;
      dec_entry_reg <= '0;
    end else begin
      dec_valid_reg <= packet_valid_i;
      if (packet_valid_i)
        dec_entry_reg <= decode_frame(packet_i, cr_ds_i, cr_p_i, cr_s_i);
    end
  end

  assign fifo_push = dec_valid_reg & (~fifo_full | rx_read_i);
  assign fifo_drop = dec_valid_reg & fifo_full & ~rx_read_i;

  always_comb begin
    ovr_next = ovr_reg;
    if (fifo_drop)        ovr_next = 1'b1;
    else if (ovr_clear_i) ovr_next = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovr_reg <= 1'b0;
    else       ovr_reg <= ovr_next;
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rx_entry_t))
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (rx_read_i),
    .wdata_i (dec_entry_reg),
    .rdata_o (fifo_rdata),
    .count_o (rx_count_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head       = fifo_rdata;
  assign rx_data_o  = head.data;
  assign rx_pe_o    = head.pe;
  assign rx_fe_o    = head.fe;
  assign rx_ready_o = ~fifo_empty;
  assign rx_full_o  = fifo_full;
  assign rx_ovr_o   = ovr_reg;

endmodule

// File: tb/tb_rx_controller.sv
// Self-checking bench for rx_controller: directed frame cases plus randomized
// traffic compared against a queue-based reference model.
module tb_rx_controller;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cr_ds_i;
  logic [1:0]  cr_p_i;
  logic        cr_s_i;
  logic [10:0] packet_i;
  logic        packet_valid_i;
  logic        rx_read_i;
  logic        ovr_clear_i;
  logic [7:0]  rx_data_o;
  logic        rx_pe_o;
  logic        rx_fe_o;
  logic        rx_ready_o;
  logic        rx_full_o;
  logic        rx_ovr_o;
  logic [2:0]  rx_count_o;

  always #5 clk_i = ~clk_i;

  rx_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cr_ds_i        (cr_ds_i),
    .cr_p_i         (cr_p_i),
    .cr_s_i         (cr_s_i),
    .packet_i       (packet_i),
    .packet_valid_i (packet_valid_i),
    .rx_read_i      (rx_read_i),
    .ovr_clear_i    (ovr_clear_i),
    .rx_data_o      (rx_data_o),
    .rx_pe_o        (rx_pe_o),
    .rx_fe_o        (rx_fe_o),
    .rx_ready_o     (rx_ready_o),
    .rx_full_o      (rx_full_o),
    .rx_ovr_o       (rx_ovr_o),
    .rx_count_o     (rx_count_o)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: buffered entries as {fe, pe, data}, plus one frame in flight.
  logic [9:0] mq[$];
  logic       m_ovr;
  logic       m_pend_v;
  logic [9:0] m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [9:0] ref_decode(input logic [10:0] pkt, input logic ds,
                                            input logic [1:0] p, input logic s);
    int         nb;
    int         ones;
    int         stop;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    nb   = ds ? 8 : 7;
    d    = 8'h00;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      d[i] = pkt[i];
      ones += int'(pkt[i]);
    end
    pe = 1'b0;
    if (p != 2'b00) begin
      ones += int'(pkt[nb]);
      pe = (p == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
    end
    stop = nb + ((p != 2'b00) ? 1 : 0);
    fe = (pkt[stop] == 1'b0) || (s && pkt[stop+1] == 1'b0);
    return {fe, pe, d};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovr    = 1'b0;
    m_pend_v = 1'b0;
    m_pend   = '0;
  endtask

  task automatic model_update();
    bit popped;
    bit drop;
    popped = rx_read_i && (mq.size() > 0);
    drop   = 0;
    if (popped) void'(mq.pop_front());
    if (m_pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend);
      else drop = 1;
    end
    if (drop) m_ovr = 1'b1;
    else if (ovr_clear_i) m_ovr = 1'b0;
    m_pend_v = packet_valid_i;
    if (packet_valid_i) m_pend = ref_decode(packet_i, cr_ds_i, cr_p_i, cr_s_i);
  endtask

  task automatic compare_model(input string pfx);
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    check({pfx, "_data"},  32'(rx_data_o),  32'(h[7:0]));
    check({pfx, "_pe"},    32'(rx_pe_o),    32'(h[8]));
    check({pfx, "_fe"},    32'(rx_fe_o),    32'(h[9]));
    check({pfx, "_ready"}, 32'(rx_ready_o), 32'(mq.size() > 0));
    check({pfx, "_full"},  32'(rx_full_o),  32'(mq.size() == DEPTH));
    check({pfx, "_ovr"},   32'(rx_ovr_o),   32'(m_ovr));
    check({pfx, "_count"}, 32'(rx_count_o), 32'(mq.size()));
  endtask

  // Called at a negedge: drive inputs, advance one clock, update model, compare.
  task automatic step(input logic stb, input logic [10:0] pkt, input logic ds,
                      input logic [1:0] p, input logic s, input logic rd, input logic clr,
                      input string pfx);
    packet_valid_i = stb;
    packet_i       = pkt;
    cr_ds_i        = ds;
    cr_p_i         = p;
    cr_s_i         = s;
    rx_read_i      = rd;
    ovr_clear_i    = clr;
    @(posedge clk_i);
    model_update();
    cyc++;
    @(negedge clk_i);
    $display("cyc %0d stb=%b pkt=%03h ds=%b p=%b s=%b rd=%b clr=%b -> count=%0d head=%02h pe=%b fe=%b ovr=%b",
             cyc, stb, pkt, ds, p, s, rd, clr, rx_count_o, rx_data_o, rx_pe_o, rx_fe_o, rx_ovr_o);
    compare_model(pfx);
  endtask

  task automatic idle(input string pfx);
    step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, pfx);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2 && (mq.size() > 0 || m_pend_v); i++)
      step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "drain");
  endtask

  task automatic async_reset_pulse();
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check("rst_count", 32'(rx_count_o), 32'd0);
    check("rst_ready", 32'(rx_ready_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    packet_valid_i = 1'b0; packet_i = '0; cr_ds_i = 1'b1; cr_p_i = 2'b00; cr_s_i = 1'b0;
    rx_read_i = 1'b0; ovr_clear_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_count", 32'(rx_count_o), 32'd0);
    check("reset_ready", 32'(rx_ready_o), 32'd0);
    check("reset_data",  32'(rx_data_o),  32'd0);
    check("reset_ovr",   32'(rx_ovr_o),   32'd0);
    check("reset_full",  32'(rx_full_o),  32'd0);

    // 8N1 with two-cycle latency
    step(1'b1, 11'h155, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "8n1_s");
    check("8n1_lat_ready", 32'(rx_ready_o), 32'd0);
    idle("8n1_i");
    check("8n1_data",  32'(rx_data_o),  32'h55);
    check("8n1_pe",    32'(rx_pe_o),    32'd0);
    check("8n1_fe",    32'(rx_fe_o),    32'd0);
    check("8n1_count", 32'(rx_count_o), 32'd1);
    drain();

    // 8E1 parity error, then same frame as odd parity
    step(1'b1, 11'h303, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "8e1");
    step(1'b1, 11'h303, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "8o1");
    idle("8e1_i");
    check("8e1_data", 32'(rx_data_o), 32'h03);
    check("8e1_pe",   32'(rx_pe_o),   32'd1);
    step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "8e1_rd");
    check("8o1_pe",   32'(rx_pe_o),   32'd0);
    drain();

    // 7O2 with second stop bit low
    step(1'b1, 11'h1C1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, "7o2");
    idle("7o2_i");
    check("7o2_data", 32'(rx_data_o), 32'h41);
    check("7o2_pe",   32'(rx_pe_o),   32'd0);
    check("7o2_fe",   32'(rx_fe_o),   32'd1);
    drain();

    // Five back-to-back 8N1 frames into a depth-4 FIFO
    for (int i = 0; i < 5; i++)
      step(1'b1, 11'h300 | 11'(8'h10 + i), 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "ovf_push");
    idle("ovf_i0");
    idle("ovf_i1");
    check("ovf_full",  32'(rx_full_o),  32'd1);
    check("ovf_ovr",   32'(rx_ovr_o),   32'd1);
    check("ovf_count", 32'(rx_count_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_head", 32'(rx_data_o), 32'(8'h10 + i));
      step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "ovf_rd");
    end
    check("ovf_empty", 32'(rx_ready_o), 32'd0);
    step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, "ovf_clr");
    check("ovf_cleared", 32'(rx_ovr_o), 32'd0);

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < 4; i++)
      step(1'b1, 11'h300 | 11'(8'h20 + i), 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "fp_fill");
    step(1'b1, 11'h3AA, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "fp_new");
    step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "fp_pushpop");
    check("fp_count", 32'(rx_count_o), 32'd4);
    check("fp_ovr",   32'(rx_ovr_o),   32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 11'h000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "fp_rd");
    check("fp_tail", 32'(rx_data_o), 32'hAA);
    drain();

    // Reset one cycle after a strobe, then a fresh frame
    step(1'b1, 11'h3C3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "rm_s");
    async_reset_pulse();
    compare_model("rm_after");
    step(1'b1, 11'h35A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "rm_new");
    idle("rm_i");
    check("rm_count", 32'(rx_count_o), 32'd1);
    check("rm_data",  32'(rx_data_o),  32'h5A);
    drain();

    // Randomized traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse();
        compare_model("rnd_rst");
      end else begin
        step($urandom_range(0, 99) < 55, 11'($urandom_range(0, 2047)), 1'($urandom),
             2'($urandom), 1'($urandom), $urandom_range(0, 99) < 35,
             $urandom_range(0, 99) < 8, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
